// File: rtl/coef_grad_bank.sv
// coef_grad_bank: per-constant gradient accumulators, read-and-clear bus drive.
// Define GRAD_ACC_SAT_EN to saturate accumulation (default build wraps).
module coef_grad_bank #(
  parameter int NC    = 99,
  parameter int N     = 16,
  parameter int G     = 4,
  parameter int LR_SH = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NC-1:0]   bp_we,
  input  logic            dtb,
  input  logic [NC*N-1:0] grad_in,
  output logic [N-1:0]    bus_out,
  output logic            bus_en,
  output logic [15:0]     samples,
  output logic            save_done,
  output logic            onehot_err
);
  localparam int A  = N + G;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  logic signed [A-1:0] acc [NC];
  logic [IW-1:0]       sel;
  logic                any_we;
  logic                one_hot;
  logic signed [A-1:0] shifted;
  logic                fits;
  logic [N-1:0]        rd_val;

  function automatic logic signed [A-1:0] acc_add(
    input logic signed [A-1:0] a,
    input logic [N-1:0]        g
  );
`ifdef GRAD_ACC_SAT_EN
    logic signed [A:0] s;
    s = {a[A-1], a} + {{(G+1){g[N-1]}}, g};
    if (s[A] != s[A-1])
      return s[A] ? {1'b1, {(A-1){1'b0}}}
                  : {1'b0, {(A-1){1'b1}}};
    return s[A-1:0];
`else
    return a + {{G{g[N-1]}}, g};
`endif
  endfunction

  always_comb begin
    sel = '0;
    for (int k = 0; k < NC; k++)
      if (bp_we[k]) sel = IW'(k);
  end

  assign any_we  = |bp_we;
  assign one_hot = any_we &&
                   ((bp_we & (bp_we - NC'(1))) == '0);
  assign shifted = acc[sel] >>> LR_SH;

  // Fits in N bits when all bits above the N-bit sign agree with it.
  assign fits = (&shifted[A-1:N-1]) || ~(|shifted[A-1:N-1]);

  always_comb begin
    if (fits)
      rd_val = shifted[N-1:0];
    else if (shifted[A-1])
      rd_val = {1'b1, {(N-1){1'b0}}};
    else
      rd_val = {1'b0, {(N-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NC; k++)
        acc[k] <= '0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (!dtb && bp_we[k])
          acc[k] <= acc_add(acc[k], grad_in[k*N +: N]);
        else if (dtb && one_hot && bp_we[k])
          acc[k] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_out    <= '0;
      bus_en     <= 1'b0;
      samples    <= '0;
      save_done  <= 1'b0;
      onehot_err <= 1'b0;
    end else begin
      unique case (1'b1)
        !dtb: begin
          bus_en    <= 1'b0;
          save_done <= 1'b0;
          if (any_we && samples != 16'hFFFF)
            samples <= samples + 16'd1;
        end
        dtb && one_hot: begin
          bus_out   <= rd_val;
          bus_en    <= 1'b1;
          save_done <= bp_we[NC-1];
          if (bp_we[NC-1])
            samples <= '0;
        end
        dtb && any_we && !one_hot: begin
          bus_out    <= '0;
          bus_en     <= 1'b0;
          save_done  <= 1'b0;
          onehot_err <= 1'b1;
        end
        default: begin
          bus_en    <= 1'b0;
          save_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_coef_grad_bank.sv
// tb_coef_grad_bank: random and directed stimulus against
// an integer-arithmetic reference model of the gradient bank.
module tb_coef_grad_bank;
  localparam int NC    = 99;
  localparam int N     = 16;
  localparam int G     = 4;
  localparam int LR_SH = 3;
  localparam int A     = N + G;
  localparam longint AMAX = (longint'(1) << (A-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (A-1));
  localparam longint AMOD = longint'(1) << A;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NC-1:0]   bp_we = '0;
  logic            dtb = 1'b0;
  logic [NC*N-1:0] grad_in = '0;
  logic [N-1:0]    bus_out;
  logic            bus_en;
  logic [15:0]     samples;
  logic            save_done;
  logic            onehot_err;

  always #5 clk = ~clk;

  coef_grad_bank #(
    .NC(NC), .N(N), .G(G), .LR_SH(LR_SH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp_we(bp_we),
    .dtb(dtb),
    .grad_in(grad_in),
    .bus_out(bus_out),
    .bus_en(bus_en),
    .samples(samples),
    .save_done(save_done),
    .onehot_err(onehot_err)
  );

  int checks = 0;
  int failures = 0;

  longint       m_acc [NC];
  int           m_samples;
  logic [N-1:0] m_bus;
  logic         m_en, m_done, m_err;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint m_add(longint a, logic [N-1:0] g);
    longint s;
    s = a + longint'($signed(g));
`ifdef GRAD_ACC_SAT_EN
    if (s > AMAX) s = AMAX;
    if (s < AMIN) s = AMIN;
`else
    s = s & (AMOD - 1);
    if (s > AMAX) s = s - AMOD;
`endif
    return s;
  endfunction

  function automatic logic [N-1:0] m_rd(longint a);
    longint v;
    v = a >>> LR_SH;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[N-1:0];
  endfunction

  function automatic logic [NC*N-1:0] rand_grad();
    logic [NC*N-1:0] g;
    for (int i = 0; i < NC; i++)
      g[i*N +: N] = N'($urandom);
    return g;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NC; i++) m_acc[i] = 0;
    m_samples = 0;
    m_bus = '0;
    m_en = 1'b0;
    m_done = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic step(string tag, logic d, logic [NC-1:0] we,
                      logic [NC*N-1:0] g);
    int cnt;
    int k;
    dtb = d;
    bp_we = we;
    grad_in = g;
    if (!d) begin
      for (int i = 0; i < NC; i++)
        if (we[i]) m_acc[i] = m_add(m_acc[i], g[i*N +: N]);
      if (we != '0 && m_samples < 65535) m_samples++;
      m_en = 1'b0;
      m_done = 1'b0;
    end else begin
      cnt = $countones(we);
      if (cnt == 1) begin
        k = 0;
        for (int i = 0; i < NC; i++) if (we[i]) k = i;
        m_bus = m_rd(m_acc[k]);
        m_acc[k] = 0;
        m_en = 1'b1;
        m_done = (k == NC-1);
        if (m_done) m_samples = 0;
      end else if (cnt > 1) begin
        m_en = 1'b0;
        m_bus = '0;
        m_err = 1'b1;
        m_done = 1'b0;
      end else begin
        m_en = 1'b0;
        m_done = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".bus_en"}, 32'(bus_en), 32'(m_en));
    check({tag, ".bus_out"}, 32'(bus_out), 32'(m_bus));
    check({tag, ".samples"}, 32'(samples), 32'(m_samples));
    check({tag, ".save_done"}, 32'(save_done), 32'(m_done));
    check({tag, ".onehot_err"}, 32'(onehot_err), 32'(m_err));
  endtask

  task automatic check_zero_outs(string tag);
    check({tag, ".bus_out"}, 32'(bus_out), 32'h0);
    check({tag, ".bus_en"}, 32'(bus_en), 32'h0);
    check({tag, ".samples"}, 32'(samples), 32'h0);
    check({tag, ".save_done"}, 32'(save_done), 32'h0);
    check({tag, ".onehot_err"}, 32'(onehot_err), 32'h0);
  endtask

  initial begin
    logic [NC*N-1:0] gv;
    logic [NC-1:0]   we;
    logic [N-1:0]    ovf_exp;
    int en_cnt, done_cnt;

    m_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outs("reset");
    @(negedge clk);
    rst = 1'b1;

    // basic accumulate then read of constant 0
    gv = rand_grad();
    gv[0 +: N] = 16'h0100;
    for (int i = 0; i < 4; i++) step("basic_acc", 1'b0, '1, gv);
    check("basic_samples", 32'(samples), 32'd4);
    step("basic_rd", 1'b1, NC'(1), gv);
    check("basic_rd_val", 32'(bus_out), 32'h0080);
    check("basic_rd_en", 32'(bus_en), 32'h1);
    step("basic_rd2", 1'b1, NC'(1), gv);
    check("basic_rd2_val", 32'(bus_out), 32'h0);

    // random legal traffic
    for (int n = 0; n < 300; n++) begin
      we = '0;
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 4) != 0)
          for (int i = 0; i < NC; i++)
            we[i] = ($urandom_range(0, 3) == 0);
        step("rand_acc", 1'b0, we, rand_grad());
      end else begin
        if ($urandom_range(0, 4) != 0)
          we = NC'(1) << $urandom_range(0, NC-1);
        step("rand_drv", 1'b1, we, rand_grad());
      end
    end

    // full walk with a few accumulations first
    for (int i = 0; i < 3; i++) step("walk_acc", 1'b0, '1, rand_grad());
    en_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < NC; k++) begin
      step("walk", 1'b1, NC'(1) << k, rand_grad());
      if (bus_en) en_cnt++;
      if (save_done) done_cnt++;
    end
    check("walk_en_cnt", 32'(en_cnt), 32'(NC));
    check("walk_done_cnt", 32'(done_cnt), 32'd1);
    check("walk_done_last", 32'(save_done), 32'h1);
    check("walk_samples", 32'(samples), 32'h0);

    // readout saturation positive / negative on k=2
    gv = '0;
    gv[2*N +: N] = 16'h7FFF;
    for (int i = 0; i < 8; i++) step("satp_acc", 1'b0, NC'(4), gv);
    step("satp_rd", 1'b1, NC'(4), gv);
    check("satp_val", 32'(bus_out), 32'h7FFF);
    gv[2*N +: N] = 16'h8000;
    for (int i = 0; i < 8; i++) step("satn_acc", 1'b0, NC'(4), gv);
    step("satn_rd", 1'b1, NC'(4), gv);
    check("satn_val", 32'(bus_out), 32'h8000);

    // accumulator overflow on k=5
    gv = '0;
    gv[5*N +: N] = 16'h7FFF;
    for (int i = 0; i < 20; i++) step("ovf_acc", 1'b0, NC'(32), gv);
    step("ovf_rd", 1'b1, NC'(32), gv);
`ifdef GRAD_ACC_SAT_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'h8000;
`endif
    check("ovf_val", 32'(bus_out), 32'(ovf_exp));

    // one-hot error, entries 0 and 1 must survive
    for (int i = 0; i < 3; i++) step("err_acc", 1'b0, NC'(3), rand_grad());
    step("err_drv", 1'b1, NC'(3), rand_grad());
    check("err_en", 32'(bus_en), 32'h0);
    check("err_bus", 32'(bus_out), 32'h0);
    check("err_flag", 32'(onehot_err), 32'h1);
    step("err_idle", 1'b1, '0, rand_grad());
    step("err_rd0", 1'b1, NC'(1), rand_grad());
    step("err_rd1", 1'b1, NC'(2), rand_grad());
    check("err_sticky", 32'(onehot_err), 32'h1);

    // reset in the middle of a walk
    for (int i = 0; i < 4; i++) step("mid_acc", 1'b0, '1, rand_grad());
    for (int k = 0; k < 5; k++)
      step("mid_walk", 1'b1, NC'(1) << k, rand_grad());
    dtb = 1'b0;
    bp_we = '0;
    rst = 1'b0;
    #1;
    m_reset();
    check_zero_outs("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step("post_rst", 1'b1, NC'(1) << $urandom_range(0, NC-1),
           rand_grad());
      check("post_rst_val", 32'(bus_out), 32'h0);
    end
    step("post_last", 1'b1, NC'(1) << (NC-1), rand_grad());
    check("post_last_val", 32'(bus_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
